// File: rtl/uart_pkg.sv
// Shared UART definitions used by the receive and transmit front ends:
// frame state encoding, parity mode codes and accumulator constants.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_ODD  = 2'b01;
    localparam logic [1:0] PAR_EVEN = 2'b10;

    localparam logic [16:0] ACC_HALF = 17'h08000;

    function automatic logic majority3(input logic [2:0] v);
        return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
    endfunction

endpackage

// File: rtl/rx_sync.sv
// Input synchroniser for the asynchronous receive line, with an optional
// three-sample majority filter (RX_FRONTEND_MAJORITY_EN), and a falling-edge
// strobe derived from the sampled value.
module rx_sync
    import uart_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic rx_i,
    output logic line_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   line_raw;
    logic                   prev_q;

    // Metastability chain; resets to the idle-high line level.
    always_ff @(posedge clk_i) begin
        if (rst_i) sync_q <= '1;
        else       sync_q <= {sync_q[SYNC_STAGES-2:0], rx_i};
    end

    assign line_raw = sync_q[SYNC_STAGES-1];

`ifdef RX_FRONTEND_MAJORITY_EN
    logic [2:0] hist_q;

    // Three-sample history so a single-cycle glitch never reaches the sampler.
    always_ff @(posedge clk_i) begin
        if (rst_i) hist_q <= 3'b111;
        else       hist_q <= {hist_q[1:0], line_raw};
    end

    assign line_o = majority3(hist_q);
`else
    assign line_o = line_raw;
`endif

    // Previous sampled value, so a line held low cannot retrigger.
    always_ff @(posedge clk_i) begin
        if (rst_i) prev_q <= 1'b1;
        else       prev_q <= line_o;
    end

    assign fall_o = prev_q & ~line_o;

endmodule

// File: rtl/rx_frontend.sv
// UART receive front end: fractional baud accumulator locates bit centres,
// FSM deserialises 7/8 data bits, optional parity, 1/2 stop bits, and
// reports the byte with parity/framing status on a one-cycle done pulse.
// Optional feature macro: RX_FRONTEND_MAJORITY_EN (majority-vote sampling).
module rx_frontend
    import uart_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [15:0] cr_acc_incr_i,
    input  logic        cr_ds_i,
    input  logic [1:0]  cr_p_i,
    input  logic        cr_s_i,
    input  logic        uart_rx_i,
    output logic [7:0]  dr_o,
    output logic        done_o,
    output logic        parity_err_o,
    output logic        frame_err_o
);

    state_t      state_q;
    logic [16:0] acc_q;
    logic [16:0] acc_d;
    logic        ovf;
    logic        line;
    logic        fall;

    logic        ds_q;
    logic [1:0]  p_q;
    logic        s_q;
    logic [7:0]  data_q;
    logic [7:0]  bit_q;
    logic [1:0]  stop_q;
    logic        par_q;
    logic        perr_q;
    logic        ferr_q;
    logic        last_bit;

    rx_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .rx_i   (uart_rx_i),
        .line_o (line),
        .fall_o (fall)
    );

    assign acc_d    = {1'b0, acc_q[15:0]} + {1'b0, cr_acc_incr_i};
    assign ovf      = acc_d[16];
    assign last_bit = ds_q ? bit_q[7] : bit_q[6];

    // Frame FSM: baud accumulator, deserialiser, parity/stop checks, result registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            acc_q        <= '0;
            dr_o         <= '0;
            done_o       <= 1'b0;
            parity_err_o <= 1'b0;
            frame_err_o  <= 1'b0;
        end else begin
            done_o <= 1'b0;
            if (state_q != IDLE) acc_q <= acc_d;
            case (state_q)
                IDLE: begin
                    if (fall) begin
                        acc_q   <= ACC_HALF;
                        ds_q    <= cr_ds_i;
                        p_q     <= cr_p_i;
                        s_q     <= cr_s_i;
                        data_q  <= '0;
                        par_q   <= cr_p_i[0];
                        perr_q  <= 1'b0;
                        ferr_q  <= 1'b0;
                        state_q <= START;
                    end
                end
                START: begin
                    if (ovf) begin
                        if (!line) begin
                            bit_q   <= 8'h01;
                            state_q <= DATA;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                DATA: begin
                    if (ovf) begin
                        if (line) data_q <= data_q | bit_q;
                        par_q <= par_q ^ line;
                        bit_q <= bit_q << 1;
                        if (last_bit) begin
                            if (p_q != PAR_NONE) begin
                                state_q <= PARITY;
                            end else begin
                                stop_q  <= s_q ? 2'b10 : 2'b01;
                                state_q <= STOP;
                            end
                        end
                    end
                end
                PARITY: begin
                    if (ovf) begin
                        perr_q  <= line ^ par_q;
                        stop_q  <= s_q ? 2'b10 : 2'b01;
                        state_q <= STOP;
                    end
                end
                STOP: begin
                    if (ovf) begin
                        if (!line) ferr_q <= 1'b1;
                        stop_q <= stop_q >> 1;
                        if (stop_q[0]) begin
                            dr_o         <= data_q;
                            parity_err_o <= perr_q;
                            frame_err_o  <= ferr_q | ~line;
                            done_o       <= 1'b1;
                            state_q      <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rx_frontend.sv
// Directed testbench for rx_frontend: 8N1, 7E1, framing error, false start,
// back-to-back frames and reset mid-frame.
module tb_rx_frontend;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [15:0] cr_acc_incr_i;
    logic        cr_ds_i;
    logic [1:0]  cr_p_i;
    logic        cr_s_i;
    logic        uart_rx_i;
    logic [7:0]  dr_o;
    logic        done_o;
    logic        parity_err_o;
    logic        frame_err_o;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    logic [9:0] log_q [0:31];

    rx_frontend #(
        .SYNC_STAGES (2)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .cr_acc_incr_i (cr_acc_incr_i),
        .cr_ds_i       (cr_ds_i),
        .cr_p_i        (cr_p_i),
        .cr_s_i        (cr_s_i),
        .uart_rx_i     (uart_rx_i),
        .dr_o          (dr_o),
        .done_o        (done_o),
        .parity_err_o  (parity_err_o),
        .frame_err_o   (frame_err_o)
    );

    always #5 clk_i = ~clk_i;

    // Record every cycle done_o is high with the status delivered alongside it.
    always @(negedge clk_i) begin
        if (done_o) begin
            if (done_cnt < 32) log_q[done_cnt] <= {parity_err_o, frame_err_o, dr_o};
            done_cnt <= done_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input int n);
        uart_rx_i = v;
        repeat (n) @(negedge clk_i);
    endtask

    task automatic send_frame(input logic [7:0] d, input int nb, input logic pen,
                              input logic pbit, input int nstop, input logic lastv,
                              input int bc);
        drive(1'b0, bc);
        for (int i = 0; i < nb; i++) drive(d[i], bc);
        if (pen) drive(pbit, bc);
        for (int i = 0; i < nstop; i++) drive((i == nstop - 1) ? lastv : 1'b1, bc);
    endtask

    initial begin
        rst_i         = 1'b1;
        uart_rx_i     = 1'b1;
        cr_acc_incr_i = 16'h1000;
        cr_ds_i       = 1'b1;
        cr_p_i        = 2'b00;
        cr_s_i        = 1'b0;
        repeat (3) @(negedge clk_i);
        check("rst_dr", {24'd0, dr_o}, 32'h0);
        check("rst_done", {31'd0, done_o}, 32'h0);
        check("rst_perr", {31'd0, parity_err_o}, 32'h0);
        check("rst_ferr", {31'd0, frame_err_o}, 32'h0);
        rst_i = 1'b0;
        drive(1'b1, 5);

        // 8N1, 0xA5
        send_frame(8'hA5, 8, 1'b0, 1'b0, 1, 1'b1, 16);
        drive(1'b1, 20);
        check("8n1_cnt", done_cnt, 1);
        check("8n1_frame", {22'd0, log_q[0]}, {22'd0, 2'b00, 8'hA5});

        // 7 bits, even parity, correct then wrong parity bit
        cr_ds_i = 1'b0;
        cr_p_i  = 2'b10;
        send_frame(8'h55, 7, 1'b1, 1'b0, 1, 1'b1, 16);
        drive(1'b1, 20);
        check("7e1_ok_cnt", done_cnt, 2);
        check("7e1_ok_frame", {22'd0, log_q[1]}, {22'd0, 2'b00, 8'h55});
        send_frame(8'h55, 7, 1'b1, 1'b1, 1, 1'b1, 16);
        drive(1'b1, 20);
        check("7e1_bad_cnt", done_cnt, 3);
        check("7e1_bad_frame", {22'd0, log_q[2]}, {22'd0, 2'b10, 8'h55});

        // 8N2 with second stop bit low, then line held low
        cr_ds_i = 1'b1;
        cr_p_i  = 2'b00;
        cr_s_i  = 1'b1;
        send_frame(8'h3A, 8, 1'b0, 1'b0, 2, 1'b0, 16);
        drive(1'b0, 20);
        check("ferr_cnt", done_cnt, 4);
        check("ferr_frame", {22'd0, log_q[3]}, {22'd0, 2'b01, 8'h3A});
        check("ferr_dr_hold", {24'd0, dr_o}, 32'h3A);
        check("ferr_flag_hold", {31'd0, frame_err_o}, 32'h1);
        drive(1'b0, 80);
        check("break_no_retrigger", done_cnt, 4);
        drive(1'b1, 30);

        // False start: 4 low cycles
        cr_s_i = 1'b0;
        drive(1'b0, 4);
        drive(1'b1, 60);
        check("false_start_cnt", done_cnt, 4);
        check("false_start_dr", {24'd0, dr_o}, 32'h3A);
`ifdef RX_FRONTEND_MAJORITY_EN
        drive(1'b0, 1);
        drive(1'b1, 60);
        check("glitch_cnt", done_cnt, 4);
`endif

        // Back-to-back 8N1 frames at 0x0C00
        cr_acc_incr_i = 16'h0C00;
        send_frame(8'h00, 8, 1'b0, 1'b0, 1, 1'b1, 21);
        send_frame(8'hFF, 8, 1'b0, 1'b0, 1, 1'b1, 21);
        drive(1'b1, 30);
        check("b2b_cnt", done_cnt, 6);
        check("b2b_frame0", {22'd0, log_q[4]}, {22'd0, 2'b00, 8'h00});
        check("b2b_frame1", {22'd0, log_q[5]}, {22'd0, 2'b00, 8'hFF});

        // Reset during DATA of 0x3C (bits 0,1 = 0, bit 2 = 1 when reset hits)
        cr_acc_incr_i = 16'h1000;
        drive(1'b0, 16);
        drive(1'b0, 16);
        drive(1'b0, 16);
        drive(1'b1, 8);
        rst_i = 1'b1;
        @(negedge clk_i);
        check("midrst_dr", {24'd0, dr_o}, 32'h0);
        check("midrst_done", {31'd0, done_o}, 32'h0);
        check("midrst_perr", {31'd0, parity_err_o}, 32'h0);
        check("midrst_ferr", {31'd0, frame_err_o}, 32'h0);
        @(negedge clk_i);
        rst_i = 1'b0;
        drive(1'b1, 40);
        check("midrst_no_pulse", done_cnt, 6);
        send_frame(8'h3C, 8, 1'b0, 1'b0, 1, 1'b1, 16);
        drive(1'b1, 20);
        check("post_rst_cnt", done_cnt, 7);
        check("post_rst_frame", {22'd0, log_q[6]}, {22'd0, 2'b00, 8'h3C});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
